// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    localparam logic [1:0] MD_DIVU  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_MULT  = 2'b11;

    localparam int ITER_COUNT = 32;

    // Magnitude for signed operations, raw bits for unsigned ones.
    function automatic logic [31:0] mag(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_mul_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);
        rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, b_i};
        acc_o   = '0;
        if (is_mul_i) begin
            // Multiplier bits are consumed from the low half as the product fills in above.
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit: 32 iterations plus one sign-fix cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mdstart,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hilosrc,
    input  logic             hilosel,
    input  logic             hiloread,
    input  logic [1:0]       hilodisable,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall
);

    localparam int CNT_W = $clog2(ITER_COUNT) + 1;

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   raw_a_q;
    logic [1:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_mul_i (op_q[0]),
        .acc_i    (acc_q),
        .b_i      (b_q),
        .acc_o    (acc_d)
    );

    assign mag_a = mag(srca, mdop[1]);
    assign mag_b = mag(srcb, mdop[1]);

    // Sign correction and divide-by-zero override applied on the way into HI/LO.
    always_comb begin
        hi_d = '0;
        lo_d = '0;
        case (op_q)
            MD_MULT:  {hi_d, lo_d} = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
            MD_MULTU: {hi_d, lo_d} = acc_q;
            default: begin
                if (b_q == '0) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    lo_d = (sa_q ^ sb_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                    hi_d = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            raw_a_q <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdstart) begin
                        // Multiply iterates over the multiplier (b); divide shifts the dividend (a).
                        acc_q   <= {{WIDTH{1'b0}}, (mdop[0] ? mag_b : mag_a)};
                        b_q     <= mdop[0] ? mag_a : mag_b;
                        raw_a_q <= srca;
                        op_q    <= mdop;
                        sa_q    <= mdop[1] & srca[WIDTH-1];
                        sb_q    <= mdop[1] & srcb[WIDTH-1];
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else if (hilosrc) begin
                        if (hilosel && !hilodisable[1]) hi_q <= srca;
                        if (!hilosel && !hilodisable[0]) lo_q <= srca;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign stall    = busy & (mdstart | hiloread | hilosrc);
    assign hilo_out = hilosel ? hi_q : lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port mdstart  input  1  start a multiply/divide this cycle.
REQ-005 SHALL have port mdop  input  2  bit1 = signed, bit0 = multiply (11 MULT, 01 MULTU, 10 DIV, 00 DIVU).
REQ-006 SHALL have port srca  input  WIDTH  rs operand: multiplicand/dividend, or the move-to data.
REQ-007 SHALL have port srcb  input  WIDTH  rt operand: multiplier/divisor.
REQ-008 SHALL have port hilosrc  input  1  direct write of srca into HI/LO (MTHI/MTLO).
REQ-009 SHALL have port hilosel  input  1  1 = HI, 0 = LO for direct read/write.
REQ-010 SHALL have port hiloread  input  1  MFHI/MFLO request.
REQ-011 SHALL have port hilodisable  input  2  {hi, lo} write inhibit for direct writes only.
REQ-012 SHALL have port hilo_out  output  WIDTH  HI when hilosel=1, else LO.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port stall  output  1  pipeline hold request.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX.
REQ-016 IDLE with mdstart=1 SHALL latch |srca| and |srcb|, the two operand signs, mdop, and raw srca, then enter RUN with counter=0.
- |x| is the magnitude when mdop[1]=1, raw bits otherwise.
REQ-017 RUN SHALL perform one radix-2 step per cycle for 32 cycles, then enter FIX.
- Multiply: shift-add on a 64-bit product.
- Divide: restoring, producing one quotient bit per cycle.
REQ-018 FIX SHALL apply sign correction, write HI and LO in the same edge, and return to IDLE.
- Signed multiply: negate the 64-bit product when the operand signs differ.
- Signed divide: quotient takes sign(a) XOR sign(b); remainder takes sign(a).
REQ-019 busy SHALL be 1 in RUN and FIX, 0 in IDLE.
- Timing: busy rises the edge after mdstart and lasts exactly 33 cycles.
- New HI/LO are visible on hilo_out the cycle busy falls.
REQ-020 Divide by zero SHALL yield HI=srca as latched and LO=0xFFFFFFFF, with the same latency.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-022 hilosrc=1 while in IDLE SHALL write srca into the register selected by hilosel, unless that register's hilodisable bit is set.
REQ-023 hilo_out SHALL be combinational from HI/LO and hilosel.
REQ-024 stall SHALL equal busy AND (mdstart OR hiloread OR hilosrc).
REQ-025 mdstart or hilosrc while busy SHALL be ignored: no restart, no operand capture, no HI/LO change.
REQ-026 mdstart and hilosrc asserted together in IDLE: the operation SHALL start and the direct write SHALL be dropped.
REQ-027 hilodisable SHALL NOT affect the writeback in FIX.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, HI=0, LO=0, counter=0, busy=0, stall=0, hilo_out=0.
- Applies at any point, including mid-RUN; the in-flight operation is discarded.
REQ-029 The first mdstart after reset_n deasserts SHALL be accepted on the next rising edge.

Structure
REQ-030 The shared package SHALL hold:
- the FSM state enum;
- mdop encodings MD_DIVU=00, MD_MULTU=01, MD_DIV=10, MD_MULT=11;
- ITER_COUNT=32.
REQ-031 The datapath MAY be a single sub-module muldiv_step, the combinational one-iteration add/subtract-shift; the FSM, counter and HI/LO registers stay in muldiv_unit.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF.
REQ-035 hiloread=1 on cycle 10 of busy -> stall=1 until busy falls; a second mdstart in that window leaves the result unchanged.
REQ-036 Direct write of 0x1234 to HI with hilodisable=10 -> HI unchanged; then reset_n pulse mid-RUN -> busy=0, HI=LO=0 immediately, no writeback.
